tx_symbol_scheduler: RTL and testbench
======================================

Name: tx_symbol_scheduler

Overview:
Per-lane TX symbol sequencer that sits directly upstream of the 8b/10b encoder and supplies exactly one byte plus K-flag every clock. It arbitrates between framed link-layer data (valid/ready), SKP ordered sets due from a periodic interval timer, and logical idle fill. SKP ordered sets are inserted only at packet boundaries, and owed SKPs are queued.

Parameters:
SKP_INTERVAL, 1180, symbol times between SKP-due events
SKP_LEN, 3, SKP (K28.0) symbols following each COM
MAX_PEND_SKP, 4, saturation limit of owed-SKP counter

Ports:
clk  input  1  clock, one symbol per cycle
reset_n  input  1  asynchronous active-low reset
tx_en_i  input  1  lane enable; low = flush to idle
in_data_i  input  8  link-layer symbol byte
in_is_k_i  input  1  byte is a K-code (framing)
in_last_i  input  1  final symbol of packet
in_valid_i  input  1  upstream symbol valid
in_ready_o  output  1  scheduler accepts symbol this cycle
sym_data_o  output  8  byte to encoder data_i
sym_is_k_o  output  1  to encoder is_special_k
skp_active_o  output  1  current sym_* is part of a SKP OS
underrun_o  output  1  one-cycle pulse: in_valid_i low mid-packet
skp_ovf_o  output  1  one-cycle pulse: SKP due while pending saturated

Behaviour:
- One clock; reset is asynchronous and active-low (reset_n); clock port clk.
- Reset values: sym_data_o=8'h00, sym_is_k_o=0, skp_active_o=0, in_ready_o=0, underrun_o=0, skp_ovf_o=0, state=IDLE, interval count=0, pending=0, sub-count=0.
- Outputs are registered; a symbol accepted (in_valid_i & in_ready_o) in cycle N appears on sym_* in N+1.
- Interval timer: increments every cycle while tx_en_i=1; at SKP_INTERVAL-1 wraps to 0 and raises skp_due for one cycle. skp_due: pending++ unless pending==MAX_PEND_SKP, in which case pending holds and skp_ovf_o pulses.
- States: IDLE (no packet open), DATA (packet open), SKP_COM, SKP_SYM.
- IDLE: if pending>0, in_ready_o=0 and go to SKP_COM, emitting the COM on the next cycle. Otherwise in_ready_o=1. An accepted symbol is emitted; go to DATA unless in_last_i=1. No valid input: emit D0.0 (8'h00, K=0).
- DATA: in_ready_o=1 regardless of pending. Accepted symbol emitted; in_last_i=1 returns to IDLE. in_valid_i=0: emit D0.0, pulse underrun_o, remain in DATA.
- SKP_COM: emit K28.5 (8'hBC, K=1, skp_active_o=1), then go to SKP_SYM with sub-count=0.
- SKP_SYM: emit K28.0 (8'h1C, K=1, skp_active_o=1). Sub-count increments; on sub-count==SKP_LEN-1: pending--, then go to SKP_COM if (post-decrement) pending>0, else IDLE. in_ready_o=0 throughout SKP_COM/SKP_SYM.
- Decrement and skp_due in the same cycle: pending unchanged (no ovf).
- Back-to-back packets: last symbol of packet A and first of B on consecutive cycles is allowed when pending==0.
- tx_en_i low: next cycle state=IDLE, counters and pending cleared, in_ready_o=0, D0.0 emitted. An in-progress SKP OS or packet is abandoned. On re-enable, timer starts from 0.
- Widths: interval counter $clog2(SKP_INTERVAL), pending $clog2(MAX_PEND_SKP+1), sub-count $clog2(SKP_LEN).

Optional Feature:
TX_SCHED_STATS_EN. Defined: adds outputs stat_skp_cnt_o[15:0] (SKP OS completed) and stat_idle_cnt_o[15:0] (D0.0 fill symbols emitted). Both saturate at 16'hFFFF, reset to 0, and clear when tx_en_i is low. Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package pcie_symbol_pkg holds the constants and the state enum:
  - K28_5_COM=8'hBC
  - K28_0_SKP=8'h1C
  - D0_0_IDLE=8'h00
  - tx_sched_state_e {IDLE, DATA, SKP_COM, SKP_SYM}
- Sub-module skp_interval_timer holds the interval counter, skp_due generation, pending counter and overflow pulse. Its inputs are enable and consume; its output is pending_nz.

Test Plan:
- SKP_INTERVAL=16, tx_en_i=1, no input -> D0.0 for 16 cycles, then BC,1C,1C,1C with skp_active_o=1, repeating every 16 cycles.
- A 5-symbol packet (FB,01,02,03,FD, last on FD) offered at cycle 0 with pending=0 -> symbols appear on cycles 1-5 in order, with K flags preserved.
- A 40-symbol packet spanning two skp_due events -> no SKP inside the packet; pending=2 at the end; two SKP OS back-to-back (8 symbols) follow immediately; in_ready_o=0 during them.
- in_valid_i dropped for 2 cycles mid-packet -> two D0.0 symbols, underrun_o pulses twice, state stays DATA, and the packet then resumes.
- MAX_PEND_SKP=4 with a 100-symbol packet at SKP_INTERVAL=16 -> pending saturates at 4, skp_ovf_o pulses on the 5th and 6th due events, and 4 SKP OS follow.
- tx_en_i deasserted during SKP_SYM -> next cycle D0.0, skp_active_o=0, pending=0. reset_n asserted mid-packet -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/pcie_symbol_pkg.sv
// Shared symbol constants and scheduler state encoding for the TX lane
// sequencer. Imported by tx_symbol_scheduler.
package pcie_symbol_pkg;

  localparam logic [7:0] K28_5_COM = 8'hBC;
  localparam logic [7:0] K28_0_SKP = 8'h1C;
  localparam logic [7:0] D0_0_IDLE = 8'h00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DATA    = 2'd1,
    SKP_COM = 2'd2,
    SKP_SYM = 2'd3
  } tx_sched_state_e;

endpackage

// File: rtl/skp_interval_timer.sv
// SKP interval timer and owed-SKP bookkeeping.
// A free-running interval counter raises an internal skp_due every
// SKP_INTERVAL enabled cycles; each due event adds one owed SKP ordered set,
// saturating at MAX_PEND_SKP (a due event lost to saturation pulses o_skp_ovf).
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   i_enable            lane enable; low clears counter and pending
//   i_consume           one owed SKP ordered set completed this cycle
//   o_pending_nz        registered pending count is non-zero
//   o_pending_nz_next   pending count after this cycle's update is non-zero
//   o_skp_ovf           one-cycle pulse: due event dropped at saturation
module skp_interval_timer #(
  parameter int SKP_INTERVAL = 1180,
  parameter int MAX_PEND_SKP = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_enable,
  input  logic i_consume,
  output logic o_pending_nz,
  output logic o_pending_nz_next,
  output logic o_skp_ovf
);

  localparam int CW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
  localparam int PW = $clog2(MAX_PEND_SKP + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SKP_INTERVAL - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND_SKP);

  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pend;
  logic          r_ovf_p1;
  logic          w_due;
  logic [PW-1:0] w_pend_next;
  logic          w_ovf;
  logic [PW:0]   w_inc;

  // Saturating increment; MSB of the result flags a dropped increment.
  function automatic logic [PW:0] pend_sat_inc(input logic [PW-1:0] v);
    if (v == PEND_MAX) return {1'b1, v};
    return {1'b0, v + PW'(1)};
  endfunction

  assign w_due = i_enable && (r_cnt == CNT_LAST);
  assign w_inc = pend_sat_inc(r_pend);

  // A completion and a due event in the same cycle cancel out.
  always_comb begin
    w_pend_next = r_pend;
    w_ovf       = 1'b0;
    if (!i_enable) begin
      w_pend_next = '0;
    end else if (w_due && !i_consume) begin
      w_pend_next = w_inc[PW-1:0];
      w_ovf       = w_inc[PW];
    end else if (!w_due && i_consume && (r_pend != '0)) begin
      w_pend_next = r_pend - PW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt    <= '0;
      r_pend   <= '0;
      r_ovf_p1 <= 1'b0;
    end else begin
      r_cnt    <= (!i_enable || w_due) ? '0 : r_cnt + CW'(1);
      r_pend   <= w_pend_next;
      r_ovf_p1 <= w_ovf;
    end
  end

  assign o_pending_nz      = (r_pend != '0);
  assign o_pending_nz_next = (w_pend_next != '0);
  assign o_skp_ovf         = r_ovf_p1;

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Per-lane TX symbol sequencer feeding the 8b/10b encoder one byte + K flag
// per clock. Chooses between link-layer packet symbols (valid/ready), SKP
// ordered sets (COM + SKP_LEN x K28.0) owed by the interval timer, and D0.0
// idle fill. SKP ordered sets only start between packets.
// Optional build macro: TX_SCHED_STATS_EN adds saturating 16-bit counters
// stat_skp_cnt_o (SKP OS completed) and stat_idle_cnt_o (D0.0 fill emitted).
// Ports:
//   clk, reset_n      clock (one symbol per cycle), async active-low reset
//   tx_en_i           lane enable; low flushes to idle
//   in_data_i[7:0]    link-layer byte      in_is_k_i  byte is a K-code
//   in_last_i         final packet symbol  in_valid_i upstream valid
//   in_ready_o        symbol accepted this cycle when in_valid_i is high
//   sym_data_o[7:0]   byte to encoder      sym_is_k_o K flag to encoder
//   skp_active_o      sym_* belongs to a SKP ordered set
//   underrun_o        pulse: valid dropped mid-packet
//   skp_ovf_o         pulse: SKP due while pending count saturated
module tx_symbol_scheduler
  import pcie_symbol_pkg::*;
#(
  parameter int SKP_INTERVAL = 1180,
  parameter int SKP_LEN      = 3,
  parameter int MAX_PEND_SKP = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        tx_en_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_is_k_i,
  input  logic        in_last_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [7:0]  sym_data_o,
  output logic        sym_is_k_o,
  output logic        skp_active_o,
  output logic        underrun_o,
  output logic        skp_ovf_o
`ifdef TX_SCHED_STATS_EN
  ,
  output logic [15:0] stat_skp_cnt_o,
  output logic [15:0] stat_idle_cnt_o
`endif
);

  localparam int SW = (SKP_LEN > 1) ? $clog2(SKP_LEN) : 1;
  localparam logic [SW-1:0] SUB_LAST = SW'(SKP_LEN - 1);

  tx_sched_state_e r_state;
  tx_sched_state_e w_state_next;
  logic [SW-1:0]   r_sub;
  logic [SW-1:0]   w_sub_next;
  logic [7:0]      r_sym_data_p1;
  logic [7:0]      w_sym_data;
  logic            r_sym_is_k_p1;
  logic            w_sym_is_k;
  logic            r_skp_active_p1;
  logic            w_skp_active;
  logic            r_underrun_p1;
  logic            w_underrun;
  logic            r_ready;
  logic            w_ready_next;
  logic            w_accept;
  logic            w_consume;
  logic            w_pend_nz;
  logic            w_pend_nz_next;
  logic            w_skp_ovf;

  assign w_accept  = in_valid_i && r_ready;
  // Kept out of the FSM block: the timer's next-pending view depends on it.
  assign w_consume = tx_en_i && (r_state == SKP_SYM) && (r_sub == SUB_LAST);

  skp_interval_timer #(
    .SKP_INTERVAL (SKP_INTERVAL),
    .MAX_PEND_SKP (MAX_PEND_SKP)
  ) u_timer (
    .clk               (clk),
    .reset_n           (reset_n),
    .i_enable          (tx_en_i),
    .i_consume         (w_consume),
    .o_pending_nz      (w_pend_nz),
    .o_pending_nz_next (w_pend_nz_next),
    .o_skp_ovf         (w_skp_ovf)
  );

  always_comb begin
    w_state_next = r_state;
    w_sub_next   = r_sub;
    w_sym_data   = D0_0_IDLE;
    w_sym_is_k   = 1'b0;
    w_skp_active = 1'b0;
    w_underrun   = 1'b0;
    if (!tx_en_i) begin
      w_state_next = IDLE;
      w_sub_next   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          // in_ready_o is already low here when SKPs are owed.
          if (w_pend_nz) begin
            w_state_next = SKP_COM;
          end else if (w_accept) begin
            w_sym_data = in_data_i;
            w_sym_is_k = in_is_k_i;
            if (!in_last_i) w_state_next = DATA;
          end
        end
        DATA: begin
          if (w_accept) begin
            w_sym_data = in_data_i;
            w_sym_is_k = in_is_k_i;
            if (in_last_i) w_state_next = IDLE;
          end else begin
            w_underrun = 1'b1;
          end
        end
        SKP_COM: begin
          w_sym_data   = K28_5_COM;
          w_sym_is_k   = 1'b1;
          w_skp_active = 1'b1;
          w_state_next = SKP_SYM;
          w_sub_next   = '0;
        end
        SKP_SYM: begin
          w_sym_data   = K28_0_SKP;
          w_sym_is_k   = 1'b1;
          w_skp_active = 1'b1;
          w_sub_next   = r_sub + SW'(1);
          if (r_sub == SUB_LAST) begin
            w_sub_next   = '0;
            w_state_next = w_pend_nz_next ? SKP_COM : IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
    // Ready is registered, so it is decided from where we land next cycle.
    w_ready_next = tx_en_i && ((w_state_next == DATA) ||
                               ((w_state_next == IDLE) && !w_pend_nz_next));
  end

  // Stage p1: registered symbol stream toward the encoder
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= IDLE;
      r_sub           <= '0;
      r_sym_data_p1   <= D0_0_IDLE;
      r_sym_is_k_p1   <= 1'b0;
      r_skp_active_p1 <= 1'b0;
      r_underrun_p1   <= 1'b0;
      r_ready         <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_sub           <= w_sub_next;
      r_sym_data_p1   <= w_sym_data;
      r_sym_is_k_p1   <= w_sym_is_k;
      r_skp_active_p1 <= w_skp_active;
      r_underrun_p1   <= w_underrun;
      r_ready         <= w_ready_next;
    end
  end

  assign in_ready_o   = r_ready;
  assign sym_data_o   = r_sym_data_p1;
  assign sym_is_k_o   = r_sym_is_k_p1;
  assign skp_active_o = r_skp_active_p1;
  assign underrun_o   = r_underrun_p1;
  assign skp_ovf_o    = w_skp_ovf;

`ifdef TX_SCHED_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) return v;
    return v + 16'd1;
  endfunction

  logic [15:0] r_stat_skp;
  logic [15:0] r_stat_idle;
  logic        w_fill;

  // Fill is any D0.0 the scheduler itself chooses while enabled.
  assign w_fill = tx_en_i && ((r_state == IDLE) || (r_state == DATA)) && !w_accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_skp  <= '0;
      r_stat_idle <= '0;
    end else if (!tx_en_i) begin
      r_stat_skp  <= '0;
      r_stat_idle <= '0;
    end else begin
      if (w_consume) r_stat_skp  <= sat_inc16(r_stat_skp);
      if (w_fill)    r_stat_idle <= sat_inc16(r_stat_idle);
    end
  end

  assign stat_skp_cnt_o  = r_stat_skp;
  assign stat_idle_cnt_o = r_stat_idle;
`endif

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
module tb_tx_symbol_scheduler;

  localparam int INTERVAL = 16;
  localparam int SLEN     = 3;
  localparam int MAXP     = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tx_en_i = 1'b0;
  logic [7:0] in_data_i = 8'h00;
  logic       in_is_k_i = 1'b0;
  logic       in_last_i = 1'b0;
  logic       in_valid_i = 1'b0;
  logic       in_ready_o;
  logic [7:0] sym_data_o;
  logic       sym_is_k_o;
  logic       skp_active_o;
  logic       underrun_o;
  logic       skp_ovf_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tx_symbol_scheduler #(
    .SKP_INTERVAL (INTERVAL),
    .SKP_LEN      (SLEN),
    .MAX_PEND_SKP (MAXP)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tx_en_i      (tx_en_i),
    .in_data_i    (in_data_i),
    .in_is_k_i    (in_is_k_i),
    .in_last_i    (in_last_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .sym_data_o   (sym_data_o),
    .sym_is_k_o   (sym_is_k_o),
    .skp_active_o (skp_active_o),
    .underrun_o   (underrun_o),
    .skp_ovf_o    (skp_ovf_o)
  );

  // Reference model: upstream symbols waiting, ordered-set symbols still to
  // go out, whether a packet is open, owed SKPs and symbol-time count.
  logic [9:0] stim_q[$];
  logic [7:0] os_q[$];
  logic       m_open = 1'b0;
  logic       m_en_q = 1'b0;
  int         m_pend = 0;
  int         m_tcnt = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_sym(input logic [7:0] d, input logic k, input logic last);
    stim_q.push_back({last, k, d});
  endtask

  task automatic push_pkt(input int len);
    for (int i = 0; i < len; i++)
      push_sym(8'($urandom), ($urandom_range(9) == 0), (i == len - 1));
  endtask

  task automatic push_os();
    os_q.push_back(8'hBC);
    for (int i = 0; i < SLEN; i++) os_q.push_back(8'h1C);
  endtask

  task automatic model_clear();
    m_open = 1'b0;
    os_q.delete();
    stim_q.delete();
    m_pend = 0;
    m_tcnt = 0;
  endtask

  // One symbol time: drive inputs, predict, clock, compare.
  task automatic cycle(input logic en, input int vpct);
    logic       exp_rdy, acc, consume, due;
    logic       e_k, e_s, e_u, e_o;
    logic [7:0] e_d;
    int         p;
    tx_en_i = en;
    if (stim_q.size() != 0 && int'($urandom_range(99)) < vpct) begin
      in_valid_i = 1'b1;
      {in_last_i, in_is_k_i, in_data_i} = stim_q[0];
    end else begin
      in_valid_i = 1'b0;
      in_data_i  = 8'($urandom);
      in_is_k_i  = 1'b0;
      in_last_i  = 1'b0;
    end
    exp_rdy = m_en_q && (m_open || (os_q.size() == 0 && m_pend == 0));
    chk("in_ready", {7'd0, in_ready_o}, {7'd0, exp_rdy});
    acc = in_valid_i && exp_rdy;
    if (acc) void'(stim_q.pop_front());
    e_d = 8'h00; e_k = 1'b0; e_s = 1'b0; e_u = 1'b0; e_o = 1'b0;
    consume = 1'b0;
    if (!en) begin
      model_clear();
    end else begin
      if (os_q.size() != 0) begin
        e_d = os_q.pop_front();
        e_k = 1'b1;
        e_s = 1'b1;
        consume = (os_q.size() == 0);
      end else if (!m_open && m_pend != 0) begin
        push_os();
      end else if (acc) begin
        e_d = in_data_i;
        e_k = in_is_k_i;
        m_open = !in_last_i;
      end else begin
        e_u = m_open;
      end
      due = (m_tcnt == INTERVAL - 1);
      m_tcnt = due ? 0 : m_tcnt + 1;
      p = m_pend - int'(consume) + int'(due);
      if (p > MAXP) begin
        p = MAXP;
        e_o = 1'b1;
      end
      m_pend = p;
      if (consume && m_pend != 0) push_os();
    end
    m_en_q = en;
    @(posedge clk);
    #1;
    chk("sym_data", sym_data_o, e_d);
    chk("sym_is_k", {7'd0, sym_is_k_o}, {7'd0, e_k});
    chk("skp_active", {7'd0, skp_active_o}, {7'd0, e_s});
    chk("underrun", {7'd0, underrun_o}, {7'd0, e_u});
    chk("skp_ovf", {7'd0, skp_ovf_o}, {7'd0, e_o});
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sym_data"}, sym_data_o, 8'h00);
    chk({tag, "_sym_is_k"}, {7'd0, sym_is_k_o}, 8'h00);
    chk({tag, "_skp_active"}, {7'd0, skp_active_o}, 8'h00);
    chk({tag, "_in_ready"}, {7'd0, in_ready_o}, 8'h00);
    chk({tag, "_underrun"}, {7'd0, underrun_o}, 8'h00);
    chk({tag, "_skp_ovf"}, {7'd0, skp_ovf_o}, 8'h00);
  endtask

  task automatic bound_check(input string tag, input int guard, input int limit);
    total++;
    assert (guard < limit) else begin
      bad++;
      $error("FAIL %s: waited=%0d cycles, required below %0d", tag, guard, limit);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    // Reset state
    #12;
    check_reset_vals("rst");
    reset_n = 1'b1;

    // Idle lane: D0.0 fill with periodic SKP ordered sets
    repeat (40) cycle(1'b1, 0);

    // Wait for a quiet boundary, then a short framed packet
    guard = 0;
    while (!(os_q.size() == 0 && m_pend == 0 && !m_open) && guard < 40) begin
      cycle(1'b1, 0);
      guard++;
    end
    bound_check("wait_quiet", guard, 40);
    push_sym(8'hFB, 1'b1, 1'b0);
    push_sym(8'h01, 1'b0, 1'b0);
    push_sym(8'h02, 1'b0, 1'b0);
    push_sym(8'h03, 1'b0, 1'b0);
    push_sym(8'hFD, 1'b1, 1'b1);
    repeat (8) cycle(1'b1, 100);

    // Long packet spanning two due events, then owed SKPs
    push_pkt(40);
    repeat (44) cycle(1'b1, 100);
    repeat (16) cycle(1'b1, 0);

    // Packet with valid gaps (underrun)
    push_pkt(20);
    guard = 0;
    while (stim_q.size() != 0 && guard < 200) begin
      cycle(1'b1, 60);
      guard++;
    end
    bound_check("gap_pkt", guard, 200);

    // Pending saturation under a 100-symbol packet
    guard = 0;
    while (!(os_q.size() == 0 && m_pend == 0 && !m_open) && guard < 60) begin
      cycle(1'b1, 0);
      guard++;
    end
    bound_check("wait_quiet2", guard, 60);
    push_pkt(100);
    repeat (102) cycle(1'b1, 100);
    repeat (30) cycle(1'b1, 0);

    // Random packets, back-to-back traffic and occasional lane disable
    for (int n = 0; n < 30; n++) begin
      push_pkt(int'($urandom_range(12, 1)));
      guard = 0;
      while (stim_q.size() != 0 && guard < 300) begin
        cycle(($urandom_range(99) < 3) ? 1'b0 : 1'b1, int'($urandom_range(100, 70)));
        guard++;
      end
      bound_check("rand_pkt", guard, 300);
    end

    // Lane disabled in the middle of a SKP ordered set
    guard = 0;
    while (!(os_q.size() >= 1 && os_q.size() <= SLEN) && guard < 60) begin
      cycle(1'b1, 0);
      guard++;
    end
    bound_check("find_skp_sym", guard, 60);
    cycle(1'b0, 0);
    repeat (24) cycle(1'b1, 0);

    // Asynchronous reset in the middle of a packet
    guard = 0;
    while (!(os_q.size() == 0 && m_pend == 0 && !m_open) && guard < 60) begin
      cycle(1'b1, 0);
      guard++;
    end
    bound_check("wait_quiet3", guard, 60);
    push_pkt(10);
    repeat (4) cycle(1'b1, 100);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_clear();
    m_en_q = 1'b0;
    #8;
    reset_n = 1'b1;
    repeat (24) cycle(1'b1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
